// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - ASCII constants and parser state encoding for the LED command parser.
package uart_cmd_pkg;

  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_1   = 8'h31;
  localparam logic [7:0] CH_3   = 8'h33;
  localparam logic [7:0] CH_ACK = 8'h4B;
  localparam logic [7:0] CH_NAK = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT_L   = 3'd1,
    ST_GOT_IDX = 3'd2,
    ST_GOT_VAL = 3'd3,
    ST_SKIP    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - Byte stream from UART_RX and start/ready handshake to UART_TX.
interface uart_cmd_parser_if;

  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;

  // master: the UART side; slave: the command parser
  modport master (
    output rx_data,
    output rx_ready,
    output tx_ready,
    input  tx_data,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  tx_ready,
    output tx_data,
    output tx_start
  );

endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - Parses 'L' <idx> <val> CR frames, drives active-low LEDs,
// answers 'K'/'E' to UART_TX and counts rejected or timed-out frames.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_parser_if.slave  bus,
  output logic [2:0]        led,
  output logic [7:0]        err_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             val_q, val_d;
  logic [2:0]       led_q, led_d;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pend_q, pend_d;

  logic ack, nak, tmo, err_inc, tx_start;

  assign tx_start     = pend_q & bus.tx_ready;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data_q;
  assign led          = led_q;
  assign err_cnt      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      val_q     <= 1'b0;
      led_q     <= 3'b111;
      err_q     <= 8'h00;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      led_q     <= led_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    led_d   = led_q;
    ack     = 1'b0;
    nak     = 1'b0;
    tmo     = 1'b0;

    if (bus.rx_ready) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == CH_L) begin
            state_d = ST_GOT_L;
          end else if (bus.rx_data != CH_CR && bus.rx_data != CH_LF) begin
            state_d = ST_SKIP;
          end
        end
        ST_GOT_L: begin
          if (bus.rx_data >= CH_1 && bus.rx_data <= CH_3) begin
            state_d = ST_GOT_IDX;
            idx_d   = bus.rx_data[1:0];
          end else if (bus.rx_data == CH_CR) begin
            state_d = ST_IDLE;
            nak     = 1'b1;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_GOT_IDX: begin
          if (bus.rx_data == CH_0 || bus.rx_data == CH_1) begin
            state_d = ST_GOT_VAL;
            val_d   = bus.rx_data[0];
          end else if (bus.rx_data == CH_CR) begin
            state_d = ST_IDLE;
            nak     = 1'b1;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_GOT_VAL: begin
          if (bus.rx_data == CH_CR) begin
            state_d             = ST_IDLE;
            ack                 = 1'b1;
            led_d[idx_q - 2'd1] = ~val_q;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (bus.rx_data == CH_CR) begin
            state_d = ST_IDLE;
            nak     = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && cnt_q == CNT_LAST) begin
      // a byte landing on the terminal count wins over the timeout
      state_d = ST_IDLE;
      tmo     = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (bus.rx_ready || state_q == ST_IDLE || tmo) begin
      cnt_d = '0;
    end
  end

  // A response arriving while one is still pending is dropped; the frame is
  // counted once as rejected even when it was itself an error frame.
  always_comb begin
    tx_data_d = tx_data_q;
    pend_d    = pend_q;
    if (tx_start) begin
      pend_d = 1'b0;
    end
    if ((ack || nak) && !pend_q) begin
      tx_data_d = ack ? CH_ACK : CH_NAK;
      pend_d    = 1'b1;
    end
    err_inc = nak | tmo | (ack & pend_q);
    err_d   = err_q;
    if (err_inc && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - Scoreboard bench for uart_cmd_parser.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] led;
  logic [7:0] err_cnt;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .led     (led),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fails   = 0;
  int         tx_pulses = 0;
  logic [7:0] exp_q[$];
  logic [2:0] exp_led   = 3'b111;
  int         exp_err   = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.tx_start === 1'b1) begin
      logic [7:0] e;
      tx_pulses++;
      n_checks++;
      if (prev_start) begin
        n_fails++;
        $display("FAIL tx_start_width: tx_start high %0d consecutive cycles, required 1", 2);
      end
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL tx_unexpected: tx_data=%h launched, required no response", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          n_fails++;
          $display("FAIL tx_data: got %h, required %h", bus.tx_data, e);
        end
      end
    end
    prev_start = !rst && (bus.tx_start === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic check_state(input string name);
    n_checks++;
    if (led !== exp_led) begin
      n_fails++;
      $display("FAIL %s_led: got %b, required %b", name, led, exp_led);
    end
    n_checks++;
    if (err_cnt !== 8'(exp_err)) begin
      n_fails++;
      $display("FAIL %s_err_cnt: got %0d, required %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (led !== 3'b111 || err_cnt !== 8'h00 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_fails++;
      $display("FAIL reset: led=%b err=%h start=%b data=%h, required 111 00 0 00",
               led, err_cnt, bus.tx_start, bus.tx_data);
    end
  endtask

  task automatic test_apply;
    bus.tx_ready = 1'b1;
    send_byte(8'h4C); send_byte(8'h32); send_byte(8'h31);
    exp_q.push_back(8'h4B);
    exp_led = 3'b101;
    send_byte(8'h0D);
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h4B) begin
      n_fails++;
      $display("FAIL apply_latency: start=%b data=%h one cycle after CR, required 1 4b",
               bus.tx_start, bus.tx_data);
    end
    check_state("apply_on");
    send_byte(8'h4C); send_byte(8'h32); send_byte(8'h30);
    exp_q.push_back(8'h4B);
    exp_led = 3'b111;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("apply_off");
    check_drained("apply");
  endtask

  task automatic test_errors;
    send_byte(8'h4C); send_byte(8'h34); send_byte(8'h31);
    exp_q.push_back(8'h45); exp_err++;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("bad_idx");
    send_byte(8'h58);
    exp_q.push_back(8'h45); exp_err++;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("skip");
    send_byte(8'h0A); send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("idle_eol");
    send_byte(8'h4C);
    exp_q.push_back(8'h45); exp_err++;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("short_frame");
    check_drained("errors");
  endtask

  task automatic test_timeout;
    int p;
    p = tx_pulses;
    send_byte(8'h4C); send_byte(8'h31);
    exp_err++;
    repeat (20) @(negedge clk);
    check_state("timeout");
    n_checks++;
    if (tx_pulses != p) begin
      n_fails++;
      $display("FAIL timeout_no_tx: %0d pulses, required %0d", tx_pulses, p);
    end
    send_byte(8'h4C); send_byte(8'h31); send_byte(8'h31);
    exp_q.push_back(8'h4B); exp_led[0] = 1'b0;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("after_timeout");
    // next byte lands exactly on the terminal count and must still be parsed
    send_byte(8'h4C);
    repeat (15) @(negedge clk);
    send_byte(8'h32); send_byte(8'h30);
    exp_q.push_back(8'h4B); exp_led[1] = 1'b1;
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    check_state("terminal_count");
    check_drained("timeout");
  endtask

  task automatic test_backpressure;
    int p;
    p = tx_pulses;
    bus.tx_ready = 1'b0;
    send_byte(8'h4C); send_byte(8'h33); send_byte(8'h31);
    exp_q.push_back(8'h4B); exp_led[2] = 1'b0;
    send_byte(8'h0D);
    send_byte(8'h51);
    exp_err++;
    send_byte(8'h0D);
    repeat (5) @(negedge clk);
    check_state("pending");
    n_checks++;
    if (tx_pulses != p) begin
      n_fails++;
      $display("FAIL pending_held: %0d pulses while tx_ready=0, required %0d", tx_pulses, p);
    end
    bus.tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_pulses != p + 1) begin
      n_fails++;
      $display("FAIL pending_release: %0d pulses, required %0d", tx_pulses, p + 1);
    end
    check_drained("backpressure");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h58);
      exp_q.push_back(8'h45);
      if (exp_err < 255) exp_err++;
      send_byte(8'h0D);
    end
    repeat (3) @(negedge clk);
    check_state("saturate");
    check_drained("saturate");
  endtask

  task automatic test_reset_midframe;
    int p;
    send_byte(8'h4C); send_byte(8'h31); send_byte(8'h31);
    rst = 1'b1;
    #1;
    exp_led = 3'b111; exp_err = 0;
    check_state("midframe_reset");
    n_checks++;
    if (bus.tx_start !== 1'b0) begin
      n_fails++;
      $display("FAIL midframe_reset_start: got %b, required 0", bus.tx_start);
    end
    @(negedge clk);
    rst = 1'b0;
    p = tx_pulses;
    send_byte(8'h0D);
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_pulses != p) begin
      n_fails++;
      $display("FAIL lone_cr: %0d pulses, required %0d", tx_pulses, p);
    end
    check_state("lone_cr");
    check_drained("final");
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_apply;
    test_errors;
    test_timeout;
    test_backpressure;
    test_saturation;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
